// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with memory handshake.
// Only the state is registered; every output is decoded combinationally from state and inputs.
module multicycle_ctrl #(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       ir_we,
  output logic       rf_we,
  output logic       dm_we,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [2:0] state,
  output logic       retire
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd7
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] FnAddu  = 6'b100001;
  localparam logic [5:0] FnSubu  = 6'b100011;

  localparam logic [1:0] AluAdd = 2'd0;
  localparam logic [1:0] AluSub = 2'd1;
  localparam logic [1:0] AluOr  = 2'd2;
  localparam logic [1:0] AluLui = 2'd3;

  localparam logic [1:0] PcPlus4  = 2'd0;
  localparam logic [1:0] PcBranch = 2'd1;
  localparam logic [1:0] PcJump   = 2'd2;

  state_e state_q, state_d;

  logic is_rtype, is_addu, is_subu, is_ori, is_lui;
  logic is_lw, is_sw, is_beq, is_j, is_alu, is_legal;
  logic [1:0] inst_alu_op;

  // Instruction decode; opcode/funct are IR fields and stable after FETCH.
  always_comb begin
    is_rtype = (opcode == OpRtype);
    is_addu  = is_rtype && (funct == FnAddu);
    is_subu  = is_rtype && (funct == FnSubu);
    is_ori   = (opcode == OpOri);
    is_lui   = (opcode == OpLui);
    is_lw    = (opcode == OpLw);
    is_sw    = (opcode == OpSw);
    is_beq   = (opcode == OpBeq);
    is_j     = (opcode == OpJ);
    is_alu   = is_addu || is_subu || is_ori || is_lui;
    is_legal = is_alu || is_lw || is_sw || is_beq || is_j;

    inst_alu_op = AluAdd;
    if (is_subu || is_beq) begin
      inst_alu_op = AluSub;
    end else if (is_ori) begin
      inst_alu_op = AluOr;
    end else if (is_lui) begin
      inst_alu_op = AluLui;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    rf_we      = 1'b0;
    dm_we      = 1'b0;
    retire     = 1'b0;
    pc_src     = PcPlus4;
    alu_op     = AluAdd;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;

    case (state_q)
      StFetch: begin
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = StDecode;
        end
      end

      StDecode: begin
        if (is_j) begin
          pc_we   = 1'b1;
          pc_src  = PcJump;
          retire  = 1'b1;
          state_d = StFetch;
        end else if (!is_legal) begin
          if (ILLEGAL_HALT) begin
            state_d = StHalt;
          end else begin
            retire  = 1'b1;
            state_d = StFetch;
          end
        end else begin
          state_d = StExec;
        end
      end

      StExec: begin
        alu_op = inst_alu_op;
        if (is_beq) begin
          pc_src  = PcBranch;
          pc_we   = zero;
          retire  = 1'b1;
          state_d = StFetch;
        end else if (is_lw || is_sw) begin
          state_d = StMem;
        end else if (is_alu) begin
          state_d = StWb;
        end else begin
          state_d = StFetch;
        end
      end

      StMem: begin
        // Address computed in EXEC stays on the ALU for the whole access.
        alu_op = inst_alu_op;
        if (mem_ready) begin
          if (is_sw) begin
            dm_we   = 1'b1;
            retire  = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end
      end

      StWb: begin
        alu_op     = inst_alu_op;
        rf_we      = 1'b1;
        retire     = 1'b1;
        reg_dst    = is_rtype;
        mem_to_reg = is_lw;
        state_d    = StFetch;
      end

      StHalt: begin
        state_d = StHalt;
      end

      default: begin
        state_d = StFetch;
      end
    endcase

    // The state register clears asynchronously, but FETCH with mem_ready=1 would still raise
    // enables, so they are masked directly while reset is held.
    if (!reset) begin
      pc_we  = 1'b0;
      ir_we  = 1'b0;
      rf_we  = 1'b0;
      dm_we  = 1'b0;
      retire = 1'b0;
    end
  end

  assign state = state_q;

  a_single_enable: assert property (@(posedge clk) disable iff (!reset)
    (state_q != StFetch) |-> $onehot0({pc_we, ir_we, rf_we, dm_we}));

  a_halt_quiet: assert property (@(posedge clk) disable iff (!reset)
    (state_q == StHalt) |-> !(pc_we || ir_we || rf_we || dm_we || retire));

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl against a per-instruction cycle-schedule model.
module tb_multicycle_ctrl;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] FnAddu  = 6'b100001;
  localparam logic [5:0] FnSubu  = 6'b100011;

  typedef enum int unsigned {KJ, KBeq, KLw, KSw, KAddu, KSubu, KOri, KLui} kind_e;

  typedef struct {
    logic [2:0] st;
    logic       mr;
    logic       z;
    logic [4:0] en;   // {pc_we, ir_we, rf_we, dm_we, retire}
    bit         chk_src;
    logic [1:0] src;
    bit         chk_alu;
    logic [1:0] alu;
    bit         chk_wb;
    logic       rdst;
    logic       m2r;
    bit         fetch;
  } cyc_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic       h_pc_we, h_ir_we, h_rf_we, h_dm_we, h_reg_dst, h_mem_to_reg, h_retire;
  logic [1:0] h_pc_src, h_alu_op;
  logic [2:0] h_state;
  logic       n_pc_we, n_ir_we, n_rf_we, n_dm_we, n_reg_dst, n_mem_to_reg, n_retire;
  logic [1:0] n_pc_src, n_alu_op;
  logic [2:0] n_state;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.ILLEGAL_HALT(1'b1)) dut_h (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_we(h_pc_we), .ir_we(h_ir_we), .rf_we(h_rf_we),
    .dm_we(h_dm_we), .pc_src(h_pc_src), .alu_op(h_alu_op), .reg_dst(h_reg_dst),
    .mem_to_reg(h_mem_to_reg), .state(h_state), .retire(h_retire)
  );

  multicycle_ctrl #(.ILLEGAL_HALT(1'b0)) dut_n (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_we(n_pc_we), .ir_we(n_ir_we), .rf_we(n_rf_we),
    .dm_we(n_dm_we), .pc_src(n_pc_src), .alu_op(n_alu_op), .reg_dst(n_reg_dst),
    .mem_to_reg(n_mem_to_reg), .state(n_state), .retire(n_retire)
  );

  wire [4:0] h_en = {h_pc_we, h_ir_we, h_rf_we, h_dm_we, h_retire};
  wire [4:0] n_en = {n_pc_we, n_ir_we, n_rf_we, n_dm_we, n_retire};

  function automatic cyc_t mk(input logic [2:0] st, input logic [4:0] en);
    cyc_t c;
    c.st = st; c.mr = 1'($urandom); c.z = 1'($urandom); c.en = en;
    c.chk_src = 0; c.src = 2'd0; c.chk_alu = 0; c.alu = 2'd0;
    c.chk_wb = 0; c.rdst = 1'b0; c.m2r = 1'b0; c.fetch = 0;
    return c;
  endfunction

  function automatic bit legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == OpRtype) return (fn == FnAddu) || (fn == FnSubu);
    return op inside {OpOri, OpLui, OpLw, OpSw, OpBeq, OpJ};
  endfunction

  // Expected cycle-by-cycle schedule for one instruction, then drive it and compare.
  task automatic run_instr(input string name, input kind_e k, input bit z, input int fw,
                           input int mw);
    cyc_t q[$];
    cyc_t c;
    logic [5:0] op, fn;
    logic [1:0] alu;
    int base, first_ret;
    fn = 6'($urandom);
    alu = 2'd0;
    case (k)
      KJ:    begin op = OpJ;   base = 2; end
      KBeq:  begin op = OpBeq; base = 3; alu = 2'd1; end
      KLw:   begin op = OpLw;  base = 5; end
      KSw:   begin op = OpSw;  base = 4; end
      KAddu: begin op = OpRtype; fn = FnAddu; base = 4; end
      KSubu: begin op = OpRtype; fn = FnSubu; base = 4; alu = 2'd1; end
      KOri:  begin op = OpOri; base = 4; alu = 2'd2; end
      default: begin op = OpLui; base = 4; alu = 2'd3; end
    endcase
    for (int i = 0; i < fw; i++) begin
      c = mk(3'd0, 5'b00000); c.mr = 1'b0; c.fetch = 1; q.push_back(c);
    end
    c = mk(3'd0, 5'b11000); c.mr = 1'b1; c.fetch = 1; c.chk_src = 1; c.src = 2'd0;
    q.push_back(c);
    if (k == KJ) begin
      c = mk(3'd1, 5'b10001); c.chk_src = 1; c.src = 2'd2; q.push_back(c);
    end else begin
      q.push_back(mk(3'd1, 5'b00000));
      if (k == KBeq) begin
        c = mk(3'd2, {z, 4'b0001}); c.z = z; c.chk_src = 1; c.src = 2'd1;
        c.chk_alu = 1; c.alu = alu; q.push_back(c);
      end else if (k == KLw || k == KSw) begin
        c = mk(3'd2, 5'b00000); c.chk_alu = 1; c.alu = 2'd0; q.push_back(c);
        for (int i = 0; i < mw; i++) begin
          c = mk(3'd3, 5'b00000); c.mr = 1'b0; c.chk_alu = 1; c.alu = 2'd0; q.push_back(c);
        end
        c = mk(3'd3, (k == KSw) ? 5'b00011 : 5'b00000); c.mr = 1'b1;
        c.chk_alu = 1; c.alu = 2'd0; q.push_back(c);
        if (k == KLw) begin
          c = mk(3'd4, 5'b00101); c.chk_alu = 1; c.alu = 2'd0;
          c.chk_wb = 1; c.rdst = 1'b0; c.m2r = 1'b1; q.push_back(c);
        end
      end else begin
        c = mk(3'd2, 5'b00000); c.chk_alu = 1; c.alu = alu; q.push_back(c);
        c = mk(3'd4, 5'b00101); c.chk_alu = 1; c.alu = alu;
        c.chk_wb = 1; c.rdst = (op == OpRtype); c.m2r = 1'b0; q.push_back(c);
      end
      if (k != KLw && k != KSw) mw = 0;
    end
    if (k == KJ) mw = 0;

    first_ret = 0;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      mem_ready = q[i].mr;
      zero = q[i].z;
      if (q[i].fetch) begin
        opcode = 6'($urandom); funct = 6'($urandom);
      end else begin
        opcode = op; funct = fn;
      end
      #1;
      n_checks++;
      if (h_state !== q[i].st)
        $display("FAIL %s c%0d state: got %0d want %0d", name, i, h_state, q[i].st);
      else n_pass++;
      n_checks++;
      if (n_state !== q[i].st)
        $display("FAIL %s c%0d state(halt=0): got %0d want %0d", name, i, n_state, q[i].st);
      else n_pass++;
      n_checks++;
      if (h_en !== q[i].en)
        $display("FAIL %s c%0d pc/ir/rf/dm/retire: got %b want %b", name, i, h_en, q[i].en);
      else n_pass++;
      if (q[i].chk_src) begin
        n_checks++;
        if (h_pc_src !== q[i].src)
          $display("FAIL %s c%0d pc_src: got %0d want %0d", name, i, h_pc_src, q[i].src);
        else n_pass++;
      end
      if (q[i].chk_alu) begin
        n_checks++;
        if (h_alu_op !== q[i].alu)
          $display("FAIL %s c%0d alu_op: got %0d want %0d", name, i, h_alu_op, q[i].alu);
        else n_pass++;
      end
      if (q[i].chk_wb) begin
        n_checks++;
        if ({h_reg_dst, h_mem_to_reg} !== {q[i].rdst, q[i].m2r})
          $display("FAIL %s c%0d reg_dst/mem_to_reg: got %b%b want %b%b", name, i,
                   h_reg_dst, h_mem_to_reg, q[i].rdst, q[i].m2r);
        else n_pass++;
      end
      if (h_retire === 1'b1 && first_ret == 0) first_ret = i + 1;
    end
    n_checks++;
    if (first_ret !== base + fw + mw)
      $display("FAIL %s latency: got %0d want %0d", name, first_ret, base + fw + mw);
    else n_pass++;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (h_state !== 3'd0 || h_en !== 5'b0)
      $display("FAIL reset_t0: got state %0d en %b want 0 00000", h_state, h_en);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_ready = (i < 2) ? 1'b1 : 1'($urandom);
      opcode = 6'($urandom); funct = 6'($urandom); zero = 1'($urandom);
      #1;
      n_checks++;
      if (h_state !== 3'd0 || h_en !== 5'b0 || n_en !== 5'b0)
        $display("FAIL reset_hold c%0d: got state %0d en %b/%b want 0 00000/00000", i,
                 h_state, h_en, n_en);
      else n_pass++;
    end
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_addu();
    run_instr("addu", KAddu, 1'b0, 0, 0);
  endtask

  task automatic test_lw_wait();
    run_instr("lw_wait", KLw, 1'b0, 0, 2);
  endtask

  task automatic test_beq();
    run_instr("beq_taken", KBeq, 1'b1, 0, 0);
    run_instr("beq_not", KBeq, 1'b0, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_instr("j0", KJ, 1'b0, 0, 0);
    run_instr("j1", KJ, 1'b0, 2, 0);
    run_instr("sw", KSw, 1'b0, 1, 1);
    run_instr("lui", KLui, 1'b0, 0, 0);
    run_instr("ori", KOri, 1'b0, 0, 0);
    run_instr("subu", KSubu, 1'b0, 0, 0);
  endtask

  task automatic test_illegal(input string name, input logic [5:0] op, input logic [5:0] fn);
    @(negedge clk);
    mem_ready = 1'b1; opcode = 6'($urandom); funct = 6'($urandom);
    #1;
    n_checks++;
    if (h_state !== 3'd0 || h_en !== 5'b11000)
      $display("FAIL %s fetch: got state %0d en %b want 0 11000", name, h_state, h_en);
    else n_pass++;
    @(negedge clk);
    mem_ready = 1'($urandom); opcode = op; funct = fn; zero = 1'($urandom);
    #1;
    n_checks++;
    if (h_state !== 3'd1 || h_en !== 5'b00000)
      $display("FAIL %s decode(halt=1): got state %0d en %b want 1 00000", name, h_state, h_en);
    else n_pass++;
    n_checks++;
    if (n_state !== 3'd1 || n_en !== 5'b00001)
      $display("FAIL %s decode(halt=0): got state %0d en %b want 1 00001", name, n_state, n_en);
    else n_pass++;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if (h_state !== 3'd7 || h_en !== 5'b00000)
      $display("FAIL %s halted: got state %0d en %b want 7 00000", name, h_state, h_en);
    else n_pass++;
    n_checks++;
    if (n_state !== 3'd0 || n_en !== 5'b00000)
      $display("FAIL %s nop_next: got state %0d en %b want 0 00000", name, n_state, n_en);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mem_ready = 1'($urandom); zero = 1'($urandom);
      opcode = 6'($urandom); funct = 6'($urandom);
      #1;
      n_checks++;
      if (h_state !== 3'd7 || h_en !== 5'b00000)
        $display("FAIL %s halt_c%0d: got state %0d en %b want 7 00000", name, i, h_state, h_en);
      else n_pass++;
    end
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if (h_state !== 3'd0 || n_state !== 3'd0 || h_en !== 5'b0 || n_en !== 5'b0)
      $display("FAIL %s halt_reset: got state %0d/%0d en %b/%b want 0/0 0/0", name,
               h_state, n_state, h_en, n_en);
    else n_pass++;
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_async_reset();
    logic [2:0] path [4];
    path[0] = 3'd0; path[1] = 3'd1; path[2] = 3'd2; path[3] = 3'd3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_ready = (i == 0) ? 1'b1 : 1'b0;
      opcode = OpSw; funct = 6'($urandom);
      #1;
      n_checks++;
      if (h_state !== path[i] || h_dm_we !== 1'b0)
        $display("FAIL async_sw c%0d: got state %0d dm_we %b want %0d 0", i, h_state, h_dm_we,
                 path[i]);
      else n_pass++;
    end
    #1;
    reset = 1'b0;
    #1;
    n_checks++;
    if (h_state !== 3'd0 || h_en !== 5'b0)
      $display("FAIL async_assert: got state %0d en %b want 0 00000", h_state, h_en);
    else n_pass++;
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if (h_en !== 5'b0)
      $display("FAIL async_mr_masked: got en %b want 00000", h_en);
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if (h_state !== 3'd0 || h_dm_we !== 1'b0)
      $display("FAIL async_held: got state %0d dm_we %b want 0 0", h_state, h_dm_we);
    else n_pass++;
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b1;
    run_instr("after_reset", KLw, 1'b0, 1, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 150; n++) begin
      run_instr("rand", kind_e'($urandom_range(0, 7)), 1'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    logic [5:0] op, fn;
    test_reset();
    test_addu();
    test_lw_wait();
    test_beq();
    test_back_to_back();
    test_illegal("ill_op3f", 6'b111111, 6'($urandom));
    fn = 6'b100000;
    op = OpRtype;
    test_illegal("ill_funct", op, fn);
    do begin
      op = 6'($urandom); fn = 6'($urandom);
    end while (legal(op, fn));
    test_illegal("ill_rand", op, fn);
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
